// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, entry type and log2 helper for the UART receive path
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef struct packed {
    logic                       err;
    logic [UART_DATA_WIDTH-1:0] data;
  } uart_entry_t;

  // Ceiling log2, usable in constant expressions for pointer widths.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - register array with one synchronous write port and one asynchronous read port
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int W     = UART_DATA_WIDTH,
  parameter int DEPTH = 16,
  localparam int AW   = log2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  // Contents are deliberately not reset; the pointers decide what is valid.
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive FIFO behind the UART receiver; UART_RX_FIFO_ERR_EN stores the parity error flag
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 16,
  localparam int AW        = log2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  rx_done,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_error,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_error,
  output logic [AW:0]           level,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  ovf_clr
);

`ifdef UART_RX_FIFO_ERR_EN
  localparam int EW = DATA_WIDTH + 1;
`else
  localparam int EW = DATA_WIDTH;
`endif

  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, drop;
  logic [EW-1:0] wdata, rdata;

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);

  // A pop frees the slot a same-cycle push needs, so full only blocks an unpaired push.
  assign pop  = ~empty & m_ready;
  assign push = rx_done & (~full | pop);
  assign drop = rx_done & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q & ~ovf_clr;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  uart_fifo_mem #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

  assign m_valid  = ~empty;
  assign overflow = ovf_q;

  // Outputs are masked while empty so stale memory never leaks onto the stream.
`ifdef UART_RX_FIFO_ERR_EN
  assign wdata   = {rx_error, rx_data};
  assign m_data  = empty ? '0 : rdata[DATA_WIDTH-1:0];
  assign m_error = ~empty & rdata[DATA_WIDTH];
`else
  logic unused_rx_error;
  assign unused_rx_error = rx_error;
  assign wdata   = rx_data;
  assign m_data  = empty ? '0 : rdata;
  assign m_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       arstn;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       rx_error;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_error;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       ovf_clr;

  int checks = 0;
  int fails  = 0;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk      (clk),
    .arstn    (arstn),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .rx_error (rx_error),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_error  (m_error),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    rx_done  = 1'b1;
    rx_data  = d;
    rx_error = e;
    tick();
    rx_done  = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic test_reset();
    arstn = 1'b0; rx_done = 1'b0; rx_data = 8'h00; rx_error = 1'b0;
    m_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    checks++; if (level !== 5'd0) begin fails++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    checks++; if (m_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", m_data); end
    arstn = 1'b1;
    tick();
  endtask

  task automatic test_single_push();
    push(8'hA5, 1'b0);
    checks++; if (m_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", m_valid); end
    checks++; if (m_data !== 8'hA5) begin fails++; $display("FAIL single_data: got %h expected a5", m_data); end
    checks++; if (level !== 5'd1) begin fails++; $display("FAIL single_level: got %0d expected 1", level); end
    checks++; if (empty !== 1'b0) begin fails++; $display("FAIL single_empty: got %b expected 0", empty); end
    tick();
    checks++; if (m_data !== 8'hA5) begin fails++; $display("FAIL single_hold: got %h expected a5", m_data); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL single_drained: got %b expected 1", empty); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    checks++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full: got %b expected 1", full); end
    checks++; if (level !== 5'd16) begin fails++; $display("FAIL fill_level: got %0d expected 16", level); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL fill_ovf_pre: got %b expected 0", overflow); end
    push(8'hFF, 1'b0);
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL fill_ovf: got %b expected 1", overflow); end
    checks++; if (level !== 5'd16) begin fails++; $display("FAIL fill_level_ovf: got %0d expected 16", level); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (m_valid !== 1'b1 || m_data !== 8'(i)) begin fails++; $display("FAIL drain_%0d: got valid %b data %h expected valid 1 data %h", i, m_valid, m_data, 8'(i)); end
      m_ready = 1'b1;
      tick();
    end
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin fails++; $display("FAIL drain_end_valid: got %b expected 0 (0xFF must be absent)", m_valid); end
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b0);
    m_ready = 1'b1;
    push(8'h55, 1'b0);
    m_ready = 1'b0;
    checks++; if (level !== 5'd16) begin fails++; $display("FAIL fullpp_level: got %0d expected 16", level); end
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL fullpp_ovf: got %b expected 0", overflow); end
    checks++; if (m_data !== 8'h11) begin fails++; $display("FAIL fullpp_head: got %h expected 11", m_data); end
  endtask

  task automatic test_ovf_clr_priority();
    ovf_clr = 1'b1;
    push(8'h66, 1'b0);
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL clr_set_wins: got %b expected 1", overflow); end
    checks++; if (level !== 5'd16) begin fails++; $display("FAIL clr_level: got %0d expected 16", level); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL clr_alone: got %b expected 0", overflow); end
    for (int i = 0; i < 16; i++) begin
      automatic logic [7:0] exp = (i < 15) ? 8'(8'h11 + i) : 8'h55;
      checks++; if (m_data !== exp) begin fails++; $display("FAIL clr_drain_%0d: got %h expected %h", i, m_data, exp); end
      m_ready = 1'b1;
      tick();
    end
    m_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL clr_drain_empty: got %b expected 1", empty); end
  endtask

  task automatic test_error_flag();
    logic exp_err;
`ifdef UART_RX_FIFO_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    push(8'h3C, 1'b1);
    checks++; if (m_data !== 8'h3C) begin fails++; $display("FAIL err_data: got %h expected 3c", m_data); end
    checks++; if (m_error !== exp_err) begin fails++; $display("FAIL err_flag: got %b expected %b", m_error, exp_err); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++; if (m_error !== 1'b0) begin fails++; $display("FAIL err_masked: got %b expected 0", m_error); end
  endtask

  task automatic test_reset_mid_stream();
    for (int i = 1; i <= 5; i++) push(8'(i), 1'b0);
    checks++; if (level !== 5'd5) begin fails++; $display("FAIL mid_level_pre: got %0d expected 5", level); end
    arstn = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL mid_empty: got %b expected 1", empty); end
    checks++; if (level !== 5'd0) begin fails++; $display("FAIL mid_level: got %0d expected 0", level); end
    checks++; if (m_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b expected 0", m_valid); end
    tick();
    arstn = 1'b1;
    tick();
    push(8'h7E, 1'b0);
    checks++; if (m_data !== 8'h7E || level !== 5'd1) begin fails++; $display("FAIL mid_repush: got data %h level %0d expected 7e level 1", m_data, level); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++; if (m_valid !== 1'b0) begin fails++; $display("FAIL mid_only_word: got valid %b expected 0", m_valid); end
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b1;
    push(8'h99, 1'b0);
    checks++; if (m_valid !== 1'b1 || m_data !== 8'h99 || level !== 5'd1) begin fails++; $display("FAIL b2b_empty_pp: got valid %b data %h level %0d expected 1 99 1", m_valid, m_data, level); end
    for (int i = 0; i < 4; i++) begin
      automatic logic [7:0] exp = (i == 0) ? 8'h99 : 8'(8'hB0 + i - 1);
      checks++; if (m_data !== exp || level !== 5'd1) begin fails++; $display("FAIL b2b_%0d: got data %h level %0d expected %h level 1", i, m_data, level, exp); end
      push(8'(8'hB0 + i), 1'b0);
    end
    checks++; if (m_data !== 8'hB3 || level !== 5'd1) begin fails++; $display("FAIL b2b_tail: got data %h level %0d expected b3 level 1", m_data, level); end
    tick();
    m_ready = 1'b0;
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL b2b_empty: got %b expected 1", empty); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_overflow();
    test_full_push_pop();
    test_ovf_clr_priority();
    test_error_flag();
    test_reset_mid_stream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer placed directly downstream of the UART receiver. Captures each single-cycle `rx_done` strobe with its `rx_data` word (and, optionally, its `rx_error` flag) into a synchronous FIFO, then presents the words to the host logic on a valid/ready stream. Reports fill level and full/empty status, and raises a sticky overflow flag when a frame arrives while the FIFO is full.

## Interface
- `DATA_WIDTH`, 8, width of the received word; must match the receiver's width.
- `DEPTH`, 16, number of FIFO entries; must be a power of two, ≥ 2.
- `clk`  in  1  system clock; the receiver runs on the same clock.
- `arstn`  in  1  asynchronous active-low reset.
- `rx_done`  in  1  single-cycle strobe: a frame has been received.
- `rx_data`  in  DATA_WIDTH  received word; valid while `rx_done`=1.
- `rx_error`  in  1  parity error for the frame; valid while `rx_done`=1.
- `m_valid`  out  1  head entry is available.
- `m_ready`  in  1  consumer accepts the head entry.
- `m_data`  out  DATA_WIDTH  head entry data.
- `m_error`  out  1  head entry error flag.
- `level`  out  AW+1  number of stored entries, where AW = log2(DEPTH).
- `full`  out  1  level == DEPTH.
- `empty`  out  1  level == 0.
- `overflow`  out  1  sticky: at least one frame was dropped.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- Storage: DEPTH × (DATA_WIDTH + 1) entries. Write pointer and read pointer are each AW+1 bits and wrap naturally. `level` = wr_ptr − rd_ptr, computed modulo 2^(AW+1).
- Push: occurs on `rx_done`=1 when not full, or when full and a pop happens in the same cycle. The word is written at wr_ptr[AW-1:0], then wr_ptr increments.
- Pop: occurs on `m_valid` & `m_ready`. rd_ptr increments. `m_ready` while empty has no effect.
- Output is first-word-fall-through: `m_data`/`m_error` are read asynchronously from rd_ptr[AW-1:0]. `m_valid` = ~`empty`. `m_data` is held stable while `m_valid`=1 and `m_ready`=0.
- Overflow: `rx_done` while full with no pop in that cycle drops the word. Memory and pointers are unchanged, and `overflow` is set to 1.
- `overflow` is cleared by `ovf_clr`=1. If a new overflow occurs in the same cycle as `ovf_clr`, set wins.
- Simultaneous push and pop when empty: only the push takes effect. No pass-through; the word appears on the next cycle.
- Simultaneous push and pop otherwise: both take effect and `level` is unchanged.
- No state machine is needed beyond the pointers. All state lives in the pointers, the memory and `overflow`.

## Timing
- Reset values: pointers 0, `level` 0, `empty` 1, `full` 0, `m_valid` 0, `overflow` 0. `m_data` and `m_error` are 0 through a reset-cleared output mask while empty; memory contents are not reset.
- Push latency: `rx_done` sampled at edge N gives `m_valid`=1 and the word on `m_data` after edge N, i.e. 1 cycle.
- Pop latency: handshake at edge N presents the next entry (or `m_valid`=0) after edge N.
- `level`, `full`, `empty` and `overflow` update at the same edge as the push or pop that changes them.
- Reset asserted mid-operation empties the FIFO immediately (asynchronous). Any frame in flight is lost.
- Sustained throughput: one push and one pop per cycle.

## Configuration
- `UART_RX_FIFO_ERR_EN` defined: `rx_error` is stored per entry and driven on `m_error`. Entry width is DATA_WIDTH+1.
- `UART_RX_FIFO_ERR_EN` undefined: entry width is DATA_WIDTH, `rx_error` is ignored, and `m_error` is tied 0. Both ports remain present in both builds.

## Structure
- Shared package `uart_pkg` holds:
  - the `log2` constant function;
  - the default DATA_WIDTH constant;
  - the entry typedef (data + error).
- One sub-module, `uart_fifo_mem`: DEPTH-entry register array with one synchronous write port and one asynchronous read port. Pointer, flag and overflow logic stay in `uart_rx_fifo`.

## Test plan
- Reset, then one `rx_done` with `rx_data`=0xA5 and `m_ready`=0 → next cycle `m_valid`=1, `m_data`=0xA5, `level`=1, `empty`=0.
- Push 16 words 0x00..0x0F with `m_ready`=0 → `full`=1, `level`=16. A 17th push of 0xFF → `overflow`=1, `level` stays 16. Draining then yields 0x00..0x0F in order, with 0xFF absent.
- While full, `rx_done` with 0x55 and `m_ready`=1 in the same cycle → pop of the head and push of 0x55 both happen, `level`=16, `overflow` stays 0.
- `ovf_clr`=1 and an overflowing `rx_done` in the same cycle → `overflow` remains 1. `ovf_clr` alone on the next cycle → `overflow`=0.
- With the macro defined, push 0x3C with `rx_error`=1 → `m_error`=1 with `m_data`=0x3C. Without the macro → `m_error`=0.
- Push 5 words, assert `arstn`=0 for 1 cycle mid-stream → `empty`=1, `level`=0, `m_valid`=0 immediately. The next push of 0x7E is the only word delivered.
